note_judge: RTL and testbench

Downstream consumer of the universal timer's 10-bit time count. Buffers upcoming chart notes (timestamp + lane) from the chart reader in a small FIFO. Compares the head note against the live time and player key presses. Emits per-note judgements (PERFECT/GOOD/MISS) plus running score and combo for the HUD/draw logic.

---
 rtl/note_judge.sv | 158 +++++++++++++++
 tb/tb_note_judge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/note_judge.sv
// note_judge: buffers upcoming chart notes and judges the head note against the live timer
// and the player's key press edges. It produces PERFECT/GOOD/MISS pulses and keeps the
// running score, combo and max_combo.
// Optional build macro: STRAY_PRESS_PENALTY_EN. When defined, any press edge that does not
// score a hit while the timer runs breaks the combo.
module note_judge #(
    parameter int unsigned TW          = 10,
    parameter int unsigned LANES       = 4,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PERFECT_WIN = 2,
    parameter int unsigned GOOD_WIN    = 6,
    parameter int unsigned SCORE_W     = 16,
    localparam int unsigned LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [TW-1:0]      time_in,
    input  logic               time_run,
    input  logic               note_valid,
    input  logic [TW-1:0]      note_time,
    input  logic [LW-1:0]      note_lane,
    output logic               note_ready,
    input  logic [LANES-1:0]   key_press,
    output logic               judge_valid,
    output logic [1:0]         judge_result,
    output logic [LW-1:0]      judge_lane,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] combo,
    output logic [SCORE_W-1:0] max_combo
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TW:0] LP_PERF = (TW+1)'(PERFECT_WIN);
    localparam logic [TW:0] LP_GOOD = (TW+1)'(GOOD_WIN);
    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ResNone, ResPerfect, ResGood, ResMiss} result_e;

    logic [TW-1:0]      r_time [DEPTH];
    logic [LW-1:0]      r_lane [DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [AW:0]        r_count;
    logic [LANES-1:0]   r_key_prev;
    logic               r_judge_valid;
    result_e            r_judge_result;
    logic [LW-1:0]      r_judge_lane;
    logic [SCORE_W-1:0] r_score, r_combo, r_max_combo;

    logic               w_flush;
    logic               w_push, w_pop;
    logic [LANES-1:0]   w_press;
    logic [TW-1:0]      w_head_time;
    logic [LW-1:0]      w_head_lane;
    logic [TW:0]        w_diff, w_adiff;
    logic               w_late, w_head_press;
    result_e            w_result;
    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_nxt, w_combo_nxt, w_max_nxt;

    assign w_flush     = reset | clear;
    assign note_ready  = (r_count != LP_FULL);
    assign w_push      = note_valid & note_ready;
    assign w_press     = key_press & ~r_key_prev;
    assign w_head_time = r_time[r_rptr];
    assign w_head_lane = r_lane[r_rptr];

    // Signed distance from the note: negative means the note is still in the future.
    assign w_diff       = {1'b0, time_in} - {1'b0, w_head_time};
    assign w_adiff      = w_diff[TW] ? (~w_diff + 1'b1) : w_diff;
    assign w_late       = !w_diff[TW] && (w_diff > LP_GOOD);
    assign w_head_press = w_press[w_head_lane];

    // Judge the head note only; at most one pop per cycle.
    always_comb begin
        w_result = ResNone;
        w_pop    = 1'b0;
        if (time_run && (r_count != '0)) begin
            if (w_head_press && (w_adiff <= LP_PERF)) begin
                w_result = ResPerfect;
                w_pop    = 1'b1;
            end else if (w_head_press && (w_adiff <= LP_GOOD)) begin
                w_result = ResGood;
                w_pop    = 1'b1;
            end else if (w_late) begin
                w_result = ResMiss;
                w_pop    = 1'b1;
            end
        end
    end

    // Next score/combo values with saturation at all-ones.
    always_comb begin
        w_score_sum = {1'b0, r_score};
        w_combo_nxt = r_combo;
        unique case (w_result)
            ResPerfect: w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(2);
            ResGood:    w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(1);
            default:    w_score_sum = {1'b0, r_score};
        endcase
        w_score_nxt = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
        if (w_result == ResPerfect || w_result == ResGood) begin
            w_combo_nxt = (r_combo == '1) ? r_combo : r_combo + SCORE_W'(1);
        end else if (w_result == ResMiss) begin
            w_combo_nxt = '0;
`ifdef STRAY_PRESS_PENALTY_EN
        end else if (time_run && (|w_press)) begin
            // Press edge that scored nothing: wrong lane, too early, or nothing queued.
            w_combo_nxt = '0;
`endif
        end
        w_max_nxt = (w_combo_nxt > r_max_combo) ? w_combo_nxt : r_max_combo;
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_time[r_wptr] <= note_time;
            r_lane[r_wptr] <= note_lane;
        end
    end

    // Pointers, count, key history, registered judgement and HUD counters.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_key_prev     <= '0;
            r_judge_valid  <= 1'b0;
            r_judge_result <= ResNone;
            r_judge_lane   <= '0;
            r_score        <= '0;
            r_combo        <= '0;
            r_max_combo    <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            r_key_prev     <= key_press;
            r_judge_valid  <= w_pop;
            r_judge_result <= w_result;
            r_judge_lane   <= w_pop ? w_head_lane : '0;
            r_score        <= w_score_nxt;
            r_combo        <= w_combo_nxt;
            r_max_combo    <= w_max_nxt;
        end
    end

    assign judge_valid  = r_judge_valid;
    assign judge_result = r_judge_result;
    assign judge_lane   = r_judge_lane;
    assign score        = r_score;
    assign combo        = r_combo;
    assign max_combo    = r_max_combo;

endmodule

// File: tb/tb_note_judge.sv
// Directed self-checking bench for note_judge (default parameters).
module tb_note_judge;

    logic        clk = 1'b0;
    logic        reset, clear, time_run, note_valid, note_ready;
    logic [9:0]  time_in, note_time;
    logic [1:0]  note_lane, judge_lane, judge_result;
    logic [3:0]  key_press;
    logic        judge_valid;
    logic [15:0] score, combo, max_combo;

    int tests = 0;
    int fails = 0;

    note_judge dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .time_in      (time_in),
        .time_run     (time_run),
        .note_valid   (note_valid),
        .note_time    (note_time),
        .note_lane    (note_lane),
        .note_ready   (note_ready),
        .key_press    (key_press),
        .judge_valid  (judge_valid),
        .judge_result (judge_result),
        .judge_lane   (judge_lane),
        .score        (score),
        .combo        (combo),
        .max_combo    (max_combo)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Check the full judgement/HUD state at once.
    task automatic check_j(input string tag, input logic v, input logic [1:0] r,
                           input logic [1:0] l, input int s, input int c, input int m);
        check({tag, ".valid"}, 32'(judge_valid), 32'(v));
        check({tag, ".result"}, 32'(judge_result), 32'(r));
        check({tag, ".lane"}, 32'(judge_lane), 32'(l));
        check({tag, ".score"}, 32'(score), 32'(s));
        check({tag, ".combo"}, 32'(combo), 32'(c));
        check({tag, ".max"}, 32'(max_combo), 32'(m));
    endtask

    task automatic push(input int t, input int l);
        note_valid = 1'b1;
        note_time  = 10'(t);
        note_lane  = 2'(l);
        tick();
        note_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; time_run = 1'b0; note_valid = 1'b0;
        time_in = '0; note_time = '0; note_lane = '0; key_press = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset.ready", 32'(note_ready), 1);
        check_j("reset", 0, 0, 0, 0, 0, 0);

        // PERFECT at +1
        time_run = 1'b1;
        push(100, 2);
        time_in = 101; key_press = 4'b0100; tick();
        check_j("perf1", 1, 1, 2, 2, 1, 1);
        key_press = '0; tick();
        check_j("perf1.idle", 0, 0, 0, 2, 1, 1);

        // GOOD at -6
        push(200, 0);
        time_in = 194; key_press = 4'b0001; tick();
        check_j("good1", 1, 2, 0, 3, 2, 2);
        key_press = '0; tick();

        // Press at -7 ignored; MISS only once diff exceeds 6
        push(200, 0);
        time_in = 193; key_press = 4'b0001; tick();
        check("early.valid", 32'(judge_valid), 0);
        key_press = '0; time_in = 206; tick();
        check("edge6.valid", 32'(judge_valid), 0);
        time_in = 207; tick();
        check_j("miss1", 1, 3, 0, 3, 0, 2);
        tick();
        check("miss1.idle", 32'(judge_valid), 0);

        // Two stale notes drain on consecutive cycles
        time_run = 1'b0; time_in = 40;
        push(50, 1); push(51, 1);
        check("paused.novalid", 32'(judge_valid), 0);
        time_run = 1'b1; time_in = 60; tick();
        check_j("stale.a", 1, 3, 1, 3, 0, 2);
        tick();
        check_j("stale.b", 1, 3, 1, 3, 0, 2);
        tick();
        check("stale.empty", 32'(judge_valid), 0);

        // Fill FIFO; 9th offer must be refused
        time_run = 1'b0; time_in = 0;
        for (int i = 0; i < 8; i++) begin
            check("fill.ready", 32'(note_ready), 1);
            push(1000 + i, 0);
        end
        check("full.ready", 32'(note_ready), 0);
        push(1008, 1);
        check("full.ready2", 32'(note_ready), 0);
        time_run = 1'b1; time_in = 1000; key_press = 4'b0001; tick();
        check_j("full.pop", 1, 1, 0, 5, 1, 2);
        check("full.ready3", 32'(note_ready), 1);
        key_press = '0; time_in = 1020;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("drain.valid", 32'(judge_valid), 1);
            check("drain.lane", 32'(judge_lane), 0);
        end
        tick();
        check("drain.done", 32'(judge_valid), 0);
        check("drain.combo", 32'(combo), 0);

        // Clear acts as reset
        clear = 1'b1; tick(); clear = 1'b0;
        check_j("clear", 0, 0, 0, 0, 0, 0);
        check("clear.ready", 32'(note_ready), 1);

        // Press during pause is not replayed on resume
        time_run = 1'b0; time_in = 300;
        push(300, 3);
        key_press = 4'b1000; tick();
        check("pause.press", 32'(judge_valid), 0);
        time_run = 1'b1; tick();
        check("resume.held", 32'(judge_valid), 0);
        key_press = '0; time_in = 301; tick();
        check("resume.rel", 32'(judge_valid), 0);
        time_in = 302; key_press = 4'b1000; tick();
        check_j("resume.perf", 1, 1, 3, 2, 1, 1);
        key_press = '0; tick();

        // P, P, P, MISS, GOOD
        clear = 1'b1; tick(); clear = 1'b0;
        time_run = 1'b0; time_in = 0;
        push(400, 1); push(410, 1); push(420, 1); push(430, 1); push(440, 1);
        time_run = 1'b1;
        time_in = 400; key_press = 4'b0010; tick();
        check_j("seq.p1", 1, 1, 1, 2, 1, 1);
        key_press = '0; tick();
        time_in = 410; key_press = 4'b0010; tick();
        check_j("seq.p2", 1, 1, 1, 4, 2, 2);
        key_press = '0; tick();
        time_in = 420; key_press = 4'b0010; tick();
        check_j("seq.p3", 1, 1, 1, 6, 3, 3);
        key_press = '0; tick();
        time_in = 437; tick();
        check_j("seq.miss", 1, 3, 1, 6, 0, 3);
        time_in = 443; key_press = 4'b0010; tick();
        check_j("seq.good", 1, 2, 1, 7, 1, 3);
        key_press = '0; tick();

        // Wrong-lane press against a lane-1 head
        push(600, 1);
        key_press = 4'b0001; tick();
`ifdef STRAY_PRESS_PENALTY_EN
        check_j("stray", 0, 0, 0, 7, 0, 3);
`else
        check_j("stray", 0, 0, 0, 7, 1, 3);
`endif
        key_press = '0; tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
